// File: rtl/sym_fir_macc_sequencer.sv
// Symmetric FIR sequencer driving one pre-add/multiply/accumulate primitive.
// One sample in, HALF mirrored-pair taps issued, one full-precision result out.
module sym_fir_macc_sequencer #(
    parameter int          NUM_TAPS    = 16,
    parameter int          DATA_W      = 24,
    parameter int          COEF_W      = 18,
    parameter int          MACC_LAT    = 3,
    parameter logic [47:0] ROUND_CONST = 48'd0
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              S_VALID,
    output logic                              S_READY,
    input  logic [DATA_W-1:0]                 S_DATA,
    output logic                              Y_VALID,
    input  logic                              Y_READY,
    output logic [47:0]                       Y_DATA,
    input  logic                              COEF_WE,
    input  logic [$clog2(NUM_TAPS/2)-1:0]     COEF_ADDR,
    input  logic [COEF_W-1:0]                 COEF_DATA,
    output logic                              M_CE,
    output logic                              M_LOAD,
    output logic [47:0]                       M_LOAD_DATA,
    output logic                              M_CARRYIN,
    output logic [24:0]                       M_PREADD1,
    output logic [24:0]                       M_PREADD2,
    output logic [COEF_W-1:0]                 M_MULTIPLIER,
    input  logic [47:0]                       M_PRODUCT
);

    localparam int HALF = NUM_TAPS / 2;
    localparam int PW   = $clog2(NUM_TAPS);
    localparam int KW   = $clog2(HALF);
    localparam int CW   = $clog2(MACC_LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state;
    logic signed [DATA_W-1:0]  dline [NUM_TAPS];
    logic signed [COEF_W-1:0]  coef  [HALF];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             newest;
    logic [KW-1:0]             k;
    logic [CW-1:0]             cnt;
    logic signed [24:0]        a_p1;
    logic signed [24:0]        a_p2;
    logic signed [COEF_W-1:0]  a_mult;
    logic                      a_load;
    logic [PW-1:0]             rd_lo;
    logic [PW-1:0]             rd_hi;

    assign rd_lo       = newest - PW'(k);
    assign rd_hi       = newest - PW'(NUM_TAPS - 1) + PW'(k);
    assign S_READY     = (state == IDLE) && !Y_VALID;
    assign M_CARRYIN   = 1'b0;
    assign M_LOAD_DATA = ROUND_CONST;

    // Taps pass through a read stage (a_*) before the M_* port registers,
    // so the drain window covers that stage plus the primitive latency.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            newest       <= '0;
            k            <= '0;
            cnt          <= '0;
            for (int i = 0; i < NUM_TAPS; i++) dline[i] <= '0;
            for (int i = 0; i < HALF; i++) coef[i] <= '0;
            a_p1         <= '0;
            a_p2         <= '0;
            a_mult       <= '0;
            a_load       <= 1'b0;
            M_CE         <= 1'b0;
            M_LOAD       <= 1'b0;
            M_PREADD1    <= '0;
            M_PREADD2    <= '0;
            M_MULTIPLIER <= '0;
            Y_VALID      <= 1'b0;
            Y_DATA       <= '0;
        end else begin
            M_CE         <= 1'b1;
            a_p1         <= '0;
            a_p2         <= '0;
            a_mult       <= '0;
            a_load       <= 1'b0;
            M_PREADD1    <= a_p1;
            M_PREADD2    <= a_p2;
            M_MULTIPLIER <= a_mult;
            M_LOAD       <= a_load;
            if (Y_VALID && Y_READY)
                Y_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (COEF_WE)
                        coef[COEF_ADDR] <= COEF_DATA;
                    if (S_VALID && S_READY) begin
                        dline[wr_ptr] <= S_DATA;
                        newest        <= wr_ptr;
                        wr_ptr        <= wr_ptr + 1'b1;
                        k             <= '0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    a_p1   <= 25'(dline[rd_lo]);
                    a_p2   <= 25'(dline[rd_hi]);
                    a_mult <= coef[k];
                    a_load <= (k == '0);
                    k      <= k + 1'b1;
                    if (k == KW'(HALF - 1)) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MACC_LAT + 1)) begin
                        Y_DATA  <= M_PRODUCT;
                        Y_VALID <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_fir_macc_sequencer.sv
// Bench for sym_fir_macc_sequencer with a behavioural ADDMACC (LATENCY=3)
// and a golden symmetric FIR model feeding an expected-result queue.
module tb_sym_fir_macc_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        S_VALID;
    logic        S_READY;
    logic [23:0] S_DATA;
    logic        Y_VALID;
    logic        Y_READY;
    logic [47:0] Y_DATA;
    logic        COEF_WE;
    logic [2:0]  COEF_ADDR;
    logic [17:0] COEF_DATA;
    logic        M_CE;
    logic        M_LOAD;
    logic [47:0] M_LOAD_DATA;
    logic        M_CARRYIN;
    logic [24:0] M_PREADD1;
    logic [24:0] M_PREADD2;
    logic [17:0] M_MULTIPLIER;
    logic [47:0] M_PRODUCT;

    sym_fir_macc_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .Y_VALID(Y_VALID), .Y_READY(Y_READY), .Y_DATA(Y_DATA),
        .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
        .M_CE(M_CE), .M_LOAD(M_LOAD), .M_LOAD_DATA(M_LOAD_DATA),
        .M_CARRYIN(M_CARRYIN), .M_PREADD1(M_PREADD1), .M_PREADD2(M_PREADD2),
        .M_MULTIPLIER(M_MULTIPLIER), .M_PRODUCT(M_PRODUCT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ADDMACC model: input regs, pre-add*mult reg, accumulator reg.
    logic signed [24:0] r_p1, r_p2;
    logic signed [17:0] r_m;
    logic               r_ld, r2_ld;
    logic signed [47:0] r_ldd, r2_ldd, r2_prod, acc;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p1 <= '0; r_p2 <= '0; r_m <= '0; r_ld <= 1'b0; r_ldd <= '0;
            r2_ld <= 1'b0; r2_ldd <= '0; r2_prod <= '0; acc <= '0;
        end else if (M_CE) begin
            r_p1    <= M_PREADD1;
            r_p2    <= M_PREADD2;
            r_m     <= M_MULTIPLIER;
            r_ld    <= M_LOAD;
            r_ldd   <= M_LOAD_DATA;
            r2_prod <= (r_p1 + r_p2) * r_m;
            r2_ld   <= r_ld;
            r2_ldd  <= r_ldd;
            acc     <= r2_ld ? r2_ldd + r2_prod : acc + r2_prod;
        end
    end
    assign M_PRODUCT = acc;

    int                 vectors = 0;
    int                 miscompares = 0;
    int                 e0 = 0;
    int                 h [8];
    logic signed [23:0] hist [16];
    logic signed [47:0] exp_q [$];
    logic signed [47:0] last_y;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag,
                   $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic signed [47:0] model_y();
        logic signed [47:0] s;
        s = 48'sd0;
        for (int j = 0; j < 8; j++)
            s += 48'(h[j]) * (48'(hist[j]) + 48'(hist[15-j]));
        return s;
    endfunction

    task automatic model_clear();
        for (int j = 0; j < 8; j++) h[j] = 0;
        for (int j = 0; j < 16; j++) hist[j] = '0;
        exp_q.delete();
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [17:0] d);
        COEF_WE = 1'b1; COEF_ADDR = a; COEF_DATA = d;
        @(negedge CLK);
        COEF_WE = 1'b0;
        h[a] = int'($signed(d));
    endtask

    task automatic send(input logic [23:0] d);
        int n = 0;
        S_DATA = d; S_VALID = 1'b1;
        while (!S_READY && n < 200) begin
            @(negedge CLK); n++;
        end
        check("s_ready_wait", 64'(S_READY), 64'd1);
        e0 = cyc + 1;
        for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = d;
        exp_q.push_back(model_y());
        @(negedge CLK);
        S_VALID = 1'b0;
    endtask

    task automatic recv(input int hold);
        int n = 0;
        logic signed [47:0] exp;
        Y_READY = 1'b0;
        while (!Y_VALID && n < 200) begin
            @(negedge CLK); n++;
        end
        check("y_latency", 64'(cyc - e0), 64'd13);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("y_data", $signed(Y_DATA), exp);
        last_y = Y_DATA;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check("hold_valid", 64'(Y_VALID), 64'd1);
            check("hold_data", $signed(Y_DATA), exp);
            check("hold_s_ready", 64'(S_READY), 64'd0);
        end
        Y_READY = 1'b1;
        check("s_ready_same", 64'(S_READY), 64'd0);
        @(negedge CLK);
        Y_READY = 1'b0;
        check("y_valid_clr", 64'(Y_VALID), 64'd0);
        check("s_ready_after", 64'(S_READY), 64'd1);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_clear();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test1();
        logic signed [47:0] t1 [17];
        for (int j = 0; j < 17; j++) t1[j] = (j < 8) ? 48'(j + 1) : 48'(16 - j);
        for (int j = 0; j < 8; j++) wr_coef(3'(j), 18'(j + 1));
        for (int j = 0; j < 17; j++) begin
            send((j == 0) ? 24'd1 : 24'd0);
            recv(0);
            check("t1_table", last_y, t1[j]);
        end
    endtask

    initial begin
        int nload;
        int kk;
        int seen;
        RST_N = 1'b0; S_VALID = 1'b0; S_DATA = '0; Y_READY = 1'b0;
        COEF_WE = 1'b0; COEF_ADDR = '0; COEF_DATA = '0;
        model_clear();
        #1;
        check("rst_m_ce", 64'(M_CE), 64'd0);
        check("rst_y_valid", 64'(Y_VALID), 64'd0);
        check("rst_y_data", 64'(Y_DATA), 64'd0);
        check("rst_m_load", 64'(M_LOAD), 64'd0);
        check("rst_preadd1", 64'(M_PREADD1), 64'd0);
        check("rst_mult", 64'(M_MULTIPLIER), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("m_ce_on", 64'(M_CE), 64'd1);
        check("s_ready_idle", 64'(S_READY), 64'd1);
        check("load_data", 64'(M_LOAD_DATA), 64'd0);
        check("carryin", 64'(M_CARRYIN), 64'd0);

        test1();

        nload = 0;
        send(24'd5);
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            kk = i - 2;
            nload += int'(M_LOAD);
            if (kk >= 0 && kk < 8) begin
                check("t2_mult", 64'(M_MULTIPLIER), 64'(kk + 1));
                check("t2_load", 64'(M_LOAD), 64'(kk == 0));
                check("t2_preadd1", 64'(M_PREADD1), (kk == 0) ? 64'd5 : 64'd0);
            end
        end
        check("t2_load_cycles", 64'(nload), 64'd1);
        recv(0);

        send(24'd3);
        recv(20);

        for (int j = 0; j < 8; j++) wr_coef(3'(j), 18'd131071);
        for (int j = 0; j < 16; j++) begin
            send(24'h7FFFFF);
            recv(0);
        end
        check("t4_pos_max", last_y, 48'sd17592049729552);
        for (int j = 0; j < 16; j++) begin
            send(24'h800000);
            recv(0);
        end
        check("t4_neg_max", last_y, -48'sd17592051826688);

        send(24'd1);
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("t5_y_valid", 64'(Y_VALID), 64'd0);
        check("t5_y_data", 64'(Y_DATA), 64'd0);
        check("t5_m_load", 64'(M_LOAD), 64'd0);
        check("t5_preadd1", 64'(M_PREADD1), 64'd0);
        check("t5_preadd2", 64'(M_PREADD2), 64'd0);
        check("t5_mult", 64'(M_MULTIPLIER), 64'd0);
        check("t5_m_ce", 64'(M_CE), 64'd0);
        model_clear();
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            seen += int'(Y_VALID);
        end
        check("t5_no_result", 64'(seen), 64'd0);
        test1();

        send(24'd7);
        COEF_WE = 1'b1; COEF_ADDR = 3'd0; COEF_DATA = 18'd99;
        repeat (3) @(negedge CLK);
        COEF_WE = 1'b0;
        recv(0);
        for (int j = 0; j < 40; j++) begin
            if (j == 12 || j == 27)
                for (int c = 0; c < 8; c++) wr_coef(3'(c), 18'($urandom));
            send(24'($urandom));
            recv(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
